// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - shared types and width helpers for the FE fetch buffer
//
// Macros:
//   BP_FE_DECLARE_FETCH_ENTRY_S(vaddr, instr) - declares bp_fe_fetch_entry_s {pc, instr}
//   BP_FE_FETCH_ENTRY_WIDTH(vaddr, instr)     - packed width of that struct
// Functions:
//   bp_fe_count_width(n) - bits needed to hold 0..n
//   bp_fe_ptr_width(n)   - bits needed to index n entries (at least 1)

`define BP_FE_DECLARE_FETCH_ENTRY_S(vaddr_width_mp, instr_width_mp) \
    typedef struct packed {                                           \
        logic [vaddr_width_mp-1:0] pc;                                \
        logic [instr_width_mp-1:0] instr;                             \
    } bp_fe_fetch_entry_s

`define BP_FE_FETCH_ENTRY_WIDTH(vaddr_width_mp, instr_width_mp) ((vaddr_width_mp) + (instr_width_mp))

package bp_fe_pkg;

    function automatic int bp_fe_count_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int bp_fe_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_fe_fetch_buffer_mem.sv
// rtl/bp_fe_fetch_buffer_mem.sv - multi-write-port, async-read entry storage
//
// Ports:
//   clk    - clock
//   w_v    - per-lane write enable
//   w_addr - per-lane write index
//   w_data - per-lane entry
//   r_addr - read index
//   r_data - entry at r_addr (combinational)

module bp_fe_fetch_buffer_mem
    import bp_fe_pkg::*;
#(
    parameter int els_p         = 8,
    parameter int fetch_width_p = 2,
    parameter int width_p       = 71,
    localparam int ptr_width_lp = bp_fe_ptr_width(els_p)
) (
    input  logic                                        clk,
    input  logic [fetch_width_p-1:0]                    w_v,
    input  logic [fetch_width_p-1:0][ptr_width_lp-1:0]  w_addr,
    input  logic [fetch_width_p-1:0][width_p-1:0]       w_data,
    input  logic [ptr_width_lp-1:0]                     r_addr,
    output logic [width_p-1:0]                          r_data
);

    logic [width_p-1:0] mem_r [els_p];

    // Lanes of one fetch always target distinct indices, so lane order
    // inside the loop never matters.
    always_ff @(posedge clk) begin
        for (int k = 0; k < fetch_width_p; k++) begin
            if (w_v[k]) begin
                mem_r[w_addr[k]] <= w_data[k];
            end
        end
    end

    assign r_data = mem_r[r_addr];

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// rtl/bp_fe_fetch_buffer.sv - multi-lane enqueue, single-lane dequeue fetch buffer
//
// Ports:
//   clk_i, reset_i      - clock, synchronous active-high reset
//   flush_i             - drop all contents and any same-cycle enqueue
//   fetch_v_i           - fetch group valid
//   fetch_count_i       - valid lanes in the group, lane 0 first
//   fetch_pc_i          - PC of lane 0
//   fetch_instr_i       - lane k at [k*instr_width_p +: instr_width_p]
//   fetch_ready_o       - room for a full-width group
//   fe_queue_v_o        - head valid
//   fe_queue_pc_o       - head PC
//   fe_queue_instr_o    - head instruction
//   fe_queue_yumi_i     - head consumed this cycle
//   count_o             - occupancy

module bp_fe_fetch_buffer
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int fetch_width_p = 2,
    parameter int els_p         = 8,
    parameter int pc_step_p     = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       flush_i,
    input  logic                                       fetch_v_i,
    input  logic [bp_fe_count_width(fetch_width_p)-1:0] fetch_count_i,
    input  logic [vaddr_width_p-1:0]                   fetch_pc_i,
    input  logic [fetch_width_p*instr_width_p-1:0]     fetch_instr_i,
    output logic                                       fetch_ready_o,
    output logic                                       fe_queue_v_o,
    output logic [vaddr_width_p-1:0]                   fe_queue_pc_o,
    output logic [instr_width_p-1:0]                   fe_queue_instr_o,
    input  logic                                       fe_queue_yumi_i,
    output logic [bp_fe_count_width(els_p)-1:0]        count_o
);

    `BP_FE_DECLARE_FETCH_ENTRY_S(vaddr_width_p, instr_width_p);

    localparam int entry_width_lp = `BP_FE_FETCH_ENTRY_WIDTH(vaddr_width_p, instr_width_p);
    localparam int ptr_width_lp   = bp_fe_ptr_width(els_p);
    localparam int count_width_lp = bp_fe_count_width(els_p);
    localparam int slack_lp       = els_p - fetch_width_p;

    logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
    logic [count_width_lp-1:0] count_r, count_next, enq_amt;
    logic                      enq, deq;

    bp_fe_fetch_entry_s [fetch_width_p-1:0]  lane_entry;
    logic [fetch_width_p-1:0]                lane_v;
    logic [fetch_width_p-1:0][ptr_width_lp-1:0] lane_addr;
    bp_fe_fetch_entry_s                      head_entry;

    // Pointer increment modulo a possibly non-power-of-2 depth. inc never
    // exceeds els_p, so a single conditional subtract is enough.
    function automatic logic [ptr_width_lp-1:0] wrap_add(input logic [ptr_width_lp-1:0] base,
                                                         input int inc);
        int sum;
        sum = int'(base) + inc;
        if (sum >= els_p) begin
            sum = sum - els_p;
        end
        return ptr_width_lp'(sum);
    endfunction

    // Ready depends only on registered occupancy so the producer never sees
    // a path from the consumer's yumi.
    assign fetch_ready_o = (int'(count_r) <= slack_lp);
    assign fe_queue_v_o  = (count_r != '0);
    assign count_o       = count_r;

    assign enq = fetch_v_i & fetch_ready_o & ~flush_i & (fetch_count_i != '0);
    assign deq = fe_queue_yumi_i & fe_queue_v_o & ~flush_i;

    always_comb begin
        lane_v     = '0;
        lane_addr  = '0;
        lane_entry = '0;
        for (int k = 0; k < fetch_width_p; k++) begin
            lane_v[k]           = enq & (k < int'(fetch_count_i));
            lane_addr[k]        = wrap_add(wptr_r, k);
            // PC wraps at vaddr_width_p bits; carry-out is intentionally lost.
            lane_entry[k].pc    = fetch_pc_i + vaddr_width_p'(k) * vaddr_width_p'(pc_step_p);
            lane_entry[k].instr = fetch_instr_i[k*instr_width_p +: instr_width_p];
        end
    end

    always_comb begin
        enq_amt    = enq ? count_width_lp'(fetch_count_i) : '0;
        count_next = count_r + enq_amt - count_width_lp'(deq);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) begin
                wptr_r <= wrap_add(wptr_r, int'(fetch_count_i));
            end
            if (deq) begin
                rptr_r <= wrap_add(rptr_r, 1);
            end
            count_r <= count_next;
        end
    end

    bp_fe_fetch_buffer_mem #(
        .els_p         (els_p),
        .fetch_width_p (fetch_width_p),
        .width_p       (entry_width_lp)
    ) mem (
        .clk    (clk_i),
        .w_v    (lane_v),
        .w_addr (lane_addr),
        .w_data (lane_entry),
        .r_addr (rptr_r),
        .r_data (head_entry)
    );

    assign fe_queue_pc_o    = head_entry.pc;
    assign fe_queue_instr_o = head_entry.instr;

    a_fetch_count_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        fetch_v_i |-> (int'(fetch_count_i) <= fetch_width_p));

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o);

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// tb/tb_bp_fe_fetch_buffer.sv - scoreboard bench for bp_fe_fetch_buffer

module tb_bp_fe_fetch_buffer;

    localparam int VW  = 39;
    localparam int IW  = 32;
    localparam int FW  = 2;
    localparam int ELS = 8;

    typedef struct packed {
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          fetch_v_i = 1'b0;
    logic [1:0]    fetch_count_i = '0;
    logic [VW-1:0] fetch_pc_i = '0;
    logic [FW*IW-1:0] fetch_instr_i = '0;
    logic          fetch_ready_o;
    logic          fe_queue_v_o;
    logic [VW-1:0] fe_queue_pc_o;
    logic [IW-1:0] fe_queue_instr_o;
    logic          fe_queue_yumi_i = 1'b0;
    logic [3:0]    count_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_count = 0;
    exp_t sb[$];

    bp_fe_fetch_buffer #(
        .vaddr_width_p (VW),
        .instr_width_p (IW),
        .fetch_width_p (FW),
        .els_p         (ELS),
        .pc_step_p     (4)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .fetch_v_i        (fetch_v_i),
        .fetch_count_i    (fetch_count_i),
        .fetch_pc_i       (fetch_pc_i),
        .fetch_instr_i    (fetch_instr_i),
        .fetch_ready_o    (fetch_ready_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_pc_o    (fe_queue_pc_o),
        .fe_queue_instr_o (fe_queue_instr_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_i && !flush_i && fe_queue_v_o && fe_queue_yumi_i) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: got head pc %0h expected no entry", fe_queue_pc_o);
                end else begin
                    e = sb.pop_front();
                    chk("head_pc", 64'(fe_queue_pc_o), 64'(e.pc));
                    chk("head_instr", 64'(fe_queue_instr_o), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // One clock of stimulus. Entered and left at posedge+1. Checks the
    // registered outputs of the current cycle against the bench's model.
    task automatic cycle(input logic fv, input int fc, input logic [VW-1:0] pc,
                         input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                         input logic y, input logic fl);
        logic m_ready, fire, ye;
        int   nxt;
        exp_t e;
        m_ready = (ELS - m_count) >= FW;
        ye      = y && (m_count != 0);
        fire    = fv && m_ready && !fl && (fc != 0);
        flush_i         = fl;
        fetch_v_i       = fv;
        fetch_count_i   = 2'(fc);
        fetch_pc_i      = pc;
        fetch_instr_i   = {i1, i0};
        fe_queue_yumi_i = ye;
        nxt = m_count - int'(ye) + (fire ? fc : 0);
        if (fl) begin
            sb.delete();
            nxt = 0;
        end
        if (fire) begin
            for (int k = 0; k < fc; k++) begin
                e.pc    = pc + VW'(4 * k);
                e.instr = (k == 0) ? i0 : i1;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        chk("count", 64'(count_o), 64'(m_count));
        chk("valid", 64'(fe_queue_v_o), 64'(m_count != 0));
        chk("ready", 64'(fetch_ready_o), 64'(m_ready));
        @(posedge clk);
        #1;
        m_count = nxt;
    endtask

    task automatic idle(input logic y);
        cycle(1'b0, 0, '0, '0, '0, y, 1'b0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        flush_i = 1'b0;
        fetch_v_i = 1'b0;
        fe_queue_yumi_i = 1'b0;
        sb.delete();
        m_count = 0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && m_count != 0; n++) idle(1'b1);
    endtask

    int fc_tab[10] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        idle(1'b0);
        idle(1'b0);

        // basic two-lane group, one head per cycle
        cycle(1'b1, 2, 39'h1000, 32'hAAAA0013, 32'hBBBB0013, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // fill to full, dropped fetch, ready returns at count 6
        for (int g = 0; g < 4; g++)
            cycle(1'b1, 2, VW'(39'h3000 + 8 * g), 32'h3000_0000 + IW'(2 * g),
                  32'h3000_0001 + IW'(2 * g), 1'b0, 1'b0);
        cycle(1'b1, 2, 39'h3F00, 32'hDEAD_DEAD, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drain();
        idle(1'b0);

        // bring wptr to 7, then a group that wraps both index and PC
        cycle(1'b1, 2, 39'h5000, 32'h5000_0000, 32'h5000_0001, 1'b1, 1'b0);
        cycle(1'b1, 2, 39'h5008, 32'h5000_0002, 32'h5000_0003, 1'b1, 1'b0);
        cycle(1'b1, 1, 39'h5010, 32'h5000_0004, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 2, 39'h7F_FFFF_FFFC, 32'h7777_0001, 32'h7777_0002, 1'b1, 1'b0);
        drain();
        idle(1'b0);

        // flush with simultaneous enqueue and yumi at count 5
        cycle(1'b1, 2, 39'h6000, 32'h6000_0000, 32'h6000_0001, 1'b0, 1'b0);
        cycle(1'b1, 2, 39'h6008, 32'h6000_0002, 32'h6000_0003, 1'b0, 1'b0);
        cycle(1'b1, 1, 39'h6010, 32'h6000_0004, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 2, 39'h6100, 32'hFFFF_0000, 32'hFFFF_0001, 1'b1, 1'b1);
        cycle(1'b1, 1, 39'h2000, 32'h2000_0013, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // single-lane and empty groups with yumi every cycle
        for (int i = 0; i < 10; i++)
            cycle(1'b1, fc_tab[i], VW'(39'h4000 + 16 * i), 32'h4000_0000 + IW'(i),
                  32'h4100_0000 + IW'(i), 1'b1, 1'b0);
        drain();
        idle(1'b0);

        // reset mid-operation
        cycle(1'b1, 2, 39'h8000, 32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
        cycle(1'b1, 2, 39'h8008, 32'h8000_0002, 32'h8000_0003, 1'b0, 1'b0);
        do_reset();
        idle(1'b0);
        cycle(1'b1, 1, 39'h9000, 32'h9000_0013, 32'h0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
